// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the data port. One transaction in flight at a time. Data
// has priority, and a streak limiter guarantees fetch progress. A response
// timeout completes a transaction if the memory model never answers.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STREAK_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iReqValid,
    output logic                  iReqReady,
    input  logic [ADDR_WIDTH-1:0] iReqAddr,
    output logic                  iRspValid,
    output logic [DATA_WIDTH-1:0] iRspData,
    input  logic                  dReqValid,
    output logic                  dReqReady,
    input  logic                  dReqWen,
    input  logic [ADDR_WIDTH-1:0] dReqAddr,
    input  logic [DATA_WIDTH-1:0] dReqData,
    input  logic [3:0]            dReqMask,
    output logic                  dRspValid,
    output logic [DATA_WIDTH-1:0] dRspData,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic                  memReqWen,
    output logic [ADDR_WIDTH-1:0] memReqAddr,
    output logic [DATA_WIDTH-1:0] memReqData,
    output logic [3:0]            memReqMask,
    input  logic                  memRspValid,
    input  logic [DATA_WIDTH-1:0] memRspData,
    output logic                  busy,
    output logic                  timeoutErr
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [1:0]            state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  owner_q, owner_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            mask_q, mask_d;
    logic                  terr_q, terr_d;

    logic                  idle;
    logic                  in_rsp;
    logic                  data_wins;
    logic                  d_grant;
    logic                  i_grant;
    logic                  timed_out;
    logic                  done;
    logic [3:0]            mask_fix;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Grant decision, mask legalisation and response routing
    always_comb begin
        idle      = (state_q == S_IDLE);
        in_rsp    = (state_q == S_RSP);
        data_wins = dReqValid && !(iReqValid && (streak_q == SW'(STREAK_MAX)));
        d_grant   = idle && data_wins;
        i_grant   = idle && !data_wins && iReqValid;

        if (dReqMask == 4'b0001 || dReqMask == 4'b0011 || dReqMask == 4'b1111) begin
            mask_fix = dReqMask;
        end else begin
            mask_fix = 4'b1111;
        end

        // A real response always beats a timeout landing in the same cycle.
        timed_out = in_rsp && !memRspValid && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
        done      = in_rsp && (memRspValid || timed_out);
        rsp_data  = (memRspValid && !wen_q) ? memRspData : '0;

        iReqReady = i_grant;
        dReqReady = d_grant;
        iRspValid = done && (owner_q == OWN_FETCH);
        dRspValid = done && (owner_q == OWN_DATA);
        iRspData  = iRspValid ? rsp_data : '0;
        dRspData  = dRspValid ? rsp_data : '0;

        memReqValid = (state_q == S_REQ);
        memReqWen   = wen_q;
        memReqAddr  = addr_q;
        memReqData  = data_q;
        memReqMask  = mask_q;
        busy        = !idle;
        timeoutErr  = terr_q;
    end

    // Next-state: FSM, request latching, streak and timeout counters
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tcnt_d   = tcnt_q;
        owner_d  = owner_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        terr_d   = terr_q;

        case (state_q)
            S_IDLE: begin
                if (d_grant) begin
                    state_d = S_REQ;
                    owner_d = OWN_DATA;
                    wen_d   = dReqWen;
                    addr_d  = dReqAddr;
                    data_d  = dReqData;
                    mask_d  = mask_fix;
                    if (!iReqValid) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(STREAK_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_grant) begin
                    state_d  = S_REQ;
                    owner_d  = OWN_FETCH;
                    wen_d    = 1'b0;
                    addr_d   = iReqAddr;
                    data_d   = '0;
                    mask_d   = 4'b1111;
                    streak_d = '0;
                end
            end
            S_REQ: begin
                if (memReqReady) begin
                    state_d = S_RSP;
                    tcnt_d  = '0;
                end
            end
            S_RSP: begin
                if (done) begin
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                    if (timed_out) begin
                        terr_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            tcnt_q   <= '0;
            owner_q  <= OWN_FETCH;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tcnt_q   <= tcnt_d;
            owner_q  <= owner_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            terr_q   <= terr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          iReqValid, iReqReady, iRspValid;
    logic [AW-1:0] iReqAddr;
    logic [DW-1:0] iRspData;
    logic          dReqValid, dReqReady, dReqWen, dRspValid;
    logic [AW-1:0] dReqAddr;
    logic [DW-1:0] dReqData, dRspData;
    logic [3:0]    dReqMask;
    logic          memReqValid, memReqReady, memReqWen, memRspValid;
    logic [AW-1:0] memReqAddr;
    logic [DW-1:0] memReqData, memRspData;
    logic [3:0]    memReqMask;
    logic          busy, timeoutErr;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STREAK_MAX    (SMAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iReqValid  (iReqValid),
        .iReqReady  (iReqReady),
        .iReqAddr   (iReqAddr),
        .iRspValid  (iRspValid),
        .iRspData   (iRspData),
        .dReqValid  (dReqValid),
        .dReqReady  (dReqReady),
        .dReqWen    (dReqWen),
        .dReqAddr   (dReqAddr),
        .dReqData   (dReqData),
        .dReqMask   (dReqMask),
        .dRspValid  (dRspValid),
        .dRspData   (dRspData),
        .memReqValid(memReqValid),
        .memReqReady(memReqReady),
        .memReqWen  (memReqWen),
        .memReqAddr (memReqAddr),
        .memReqData (memReqData),
        .memReqMask (memReqMask),
        .memRspValid(memRspValid),
        .memRspData (memRspData),
        .busy       (busy),
        .timeoutErr (timeoutErr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference model
    bit          m_busy, m_hs, m_own_d, m_wen, m_terr;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_mask;
    int          m_wait, m_streak;

    // Last sampled DUT outputs
    logic        s_iready, s_dready, s_mrv, s_mwen, s_irv, s_drv, s_busy;
    logic [31:0] s_maddr, s_mdata, s_ird, s_drd;
    logic [3:0]  s_mmask;

    byte grant_log[$];
    bit  log_on = 1'b0;

    function automatic logic [3:0] legal_mask(input logic [3:0] m);
        return (m == 4'h1 || m == 4'h3 || m == 4'hF) ? m : 4'hF;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_hs = 0; m_own_d = 0; m_wen = 0; m_terr = 0;
        m_addr = '0; m_data = '0; m_mask = '0; m_wait = 0; m_streak = 0;
    endtask

    // Inputs are set at the falling edge; check, cross the rising edge, update model.
    task automatic step();
        bit          dwin, ig, dg, fire, exp_mrv;
        logic [31:0] rdata;
        #1;
        s_iready = iReqReady; s_dready = dReqReady; s_mrv = memReqValid;
        s_mwen = memReqWen; s_maddr = memReqAddr; s_mdata = memReqData;
        s_mmask = memReqMask; s_irv = iRspValid; s_ird = iRspData;
        s_drv = dRspValid; s_drd = dRspData; s_busy = busy;

        dwin    = dReqValid && !(iReqValid && m_streak == SMAX);
        ig      = !m_busy && iReqValid && !dwin;
        dg      = !m_busy && dwin;
        exp_mrv = m_busy && !m_hs;
        fire    = m_busy && m_hs && (memRspValid || m_wait == TMO - 1);
        rdata   = (memRspValid && !(m_own_d && m_wen)) ? memRspData : 32'h0;

        check_eq("iReqReady", s_iready, ig);
        check_eq("dReqReady", s_dready, dg);
        check_eq("memReqValid", s_mrv, exp_mrv);
        if (exp_mrv) begin
            check_eq("memReqAddr", s_maddr, m_addr);
            check_eq("memReqWen", s_mwen, m_wen);
            check_eq("memReqMask", s_mmask, m_mask);
            if (m_own_d && m_wen) check_eq("memReqData", s_mdata, m_data);
        end
        check_eq("iRspValid", s_irv, fire && !m_own_d);
        check_eq("dRspValid", s_drv, fire && m_own_d);
        if (fire && !m_own_d) check_eq("iRspData", s_ird, rdata);
        if (fire && m_own_d)  check_eq("dRspData", s_drd, rdata);
        check_eq("busy", s_busy, m_busy);
        check_eq("timeoutErr", timeoutErr, m_terr);
        if (log_on && s_iready) grant_log.push_back("I");
        if (log_on && s_dready) grant_log.push_back("D");

        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (ig || dg) begin
                m_busy = 1; m_hs = 0; m_wait = 0; m_own_d = dg;
                m_addr = dg ? dReqAddr : iReqAddr;
                m_wen  = dg && dReqWen;
                m_mask = dg ? legal_mask(dReqMask) : 4'hF;
                m_data = dReqData;
            end
            if (ig) m_streak = 0;
            else if (dg) m_streak = iReqValid ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
        end else if (!m_hs) begin
            if (memReqReady) m_hs = 1;
        end else if (fire) begin
            m_busy = 0;
            if (!memRspValid) m_terr = 1;
        end else begin
            m_wait++;
        end
        @(negedge clock);
    endtask

    task automatic quiet();
        iReqValid = 0; iReqAddr = '0; dReqValid = 0; dReqWen = 0;
        dReqAddr = '0; dReqData = '0; dReqMask = '0;
        memReqReady = 0; memRspValid = 0; memRspData = '0;
    endtask

    initial begin
        string       order;
        logic [31:0] hold_addr, hold_data;
        int          k;

        reset = 1;
        quiet();
        model_reset();
        @(negedge clock);
        step();
        step();
        check_eq("reset_busy", s_busy, 0);
        check_eq("reset_memReqValid", s_mrv, 0);
        reset = 0;
        step();

        // Single fetch
        iReqValid = 1; iReqAddr = 32'h8000_0000;
        step();
        check_eq("fetch_ready", s_iready, 1);
        iReqValid = 0; memReqReady = 1;
        step();
        check_eq("fetch_memValid", s_mrv, 1);
        check_eq("fetch_memAddr", s_maddr, 32'h8000_0000);
        memRspValid = 1; memRspData = 32'h0000_0013;
        step();
        check_eq("fetch_rspValid", s_irv, 1);
        check_eq("fetch_rspData", s_ird, 32'h0000_0013);
        check_eq("fetch_noData", s_drv, 0);
        quiet();
        step();

        // Byte write
        dReqValid = 1; dReqWen = 1; dReqAddr = 32'h8000_1003; dReqData = 32'hAB; dReqMask = 4'b0001;
        step();
        check_eq("wr_ready", s_dready, 1);
        quiet(); memReqReady = 1;
        step();
        check_eq("wr_memWen", s_mwen, 1);
        check_eq("wr_memMask", s_mmask, 4'b0001);
        check_eq("wr_memData", s_mdata, 32'hAB);
        check_eq("wr_memAddr", s_maddr, 32'h8000_1003);
        memRspValid = 1; memRspData = 32'hDEAD_BEEF;
        step();
        check_eq("wr_rspValid", s_drv, 1);
        check_eq("wr_rspData", s_drd, 0);
        quiet();
        step();

        // Contention with an always-ready memory
        log_on = 1;
        iReqValid = 1; dReqValid = 1; memReqReady = 1; memRspValid = 1;
        for (int i = 0; i < 36; i++) begin
            iReqAddr = $urandom; dReqAddr = $urandom; dReqData = $urandom;
            dReqWen = 1'($urandom); dReqMask = 4'($urandom); memRspData = $urandom;
            step();
        end
        log_on = 0;
        quiet();
        step();
        order = "DDDDIDDDDI";
        check_eq("grant_count", (grant_log.size() >= 10), 1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check_eq("grant_order", grant_log[i], order[i]);

        // Backpressure
        hold_addr = $urandom; hold_data = $urandom;
        dReqValid = 1; dReqWen = 1; dReqAddr = hold_addr; dReqData = hold_data; dReqMask = 4'b0011;
        step();
        quiet(); iReqValid = 1; iReqAddr = $urandom;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_valid", s_mrv, 1);
            check_eq("bp_addr", s_maddr, hold_addr);
            check_eq("bp_data", s_mdata, hold_data);
            check_eq("bp_mask", s_mmask, 4'b0011);
            check_eq("bp_noReady", s_iready | s_dready, 0);
        end
        quiet(); memReqReady = 1;
        step();
        memRspValid = 1; memRspData = $urandom;
        step();
        check_eq("bp_rsp", s_drv, 1);
        quiet();
        step();

        // Timeout
        iReqValid = 1; iReqAddr = 32'h0000_0100;
        step();
        iReqValid = 0; memReqReady = 1;
        step();
        memReqReady = 0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_irv) begin
                k = i;
                break;
            end
        end
        check_eq("tmo_latency", k, TMO);
        check_eq("tmo_data", s_ird, 0);
        check_eq("tmo_err", timeoutErr, 1);
        step();
        check_eq("tmo_err_held", timeoutErr, 1);
        dReqValid = 1; dReqAddr = 32'h40; dReqMask = 4'hF;
        step();
        quiet(); memReqReady = 1;
        step();
        memRspValid = 1; memRspData = 32'h1234_5678;
        step();
        check_eq("post_tmo_rsp", s_drv, 1);
        check_eq("post_tmo_data", s_drd, 32'h1234_5678);
        quiet();
        step();

        // Reset while in RSP
        iReqValid = 1; iReqAddr = 32'h200;
        step();
        iReqValid = 0; memReqReady = 1;
        step();
        memReqReady = 0;
        step();
        reset = 1;
        step();
        reset = 0; memRspValid = 1; memRspData = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_no_rsp", s_irv | s_drv, 0);
            check_eq("rst_idle", s_busy, 0);
        end
        check_eq("rst_err_clear", timeoutErr, 0);
        quiet();
        step();

        // Randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            int rsp_pct;
            rsp_pct = (blk % 3 == 2) ? 3 : 35;
            for (int i = 0; i < 200; i++) begin
                reset       = ($urandom_range(0, 299) == 0);
                iReqValid   = ($urandom_range(0, 99) < 50);
                iReqAddr    = $urandom;
                dReqValid   = ($urandom_range(0, 99) < 50);
                dReqWen     = 1'($urandom);
                dReqAddr    = $urandom;
                dReqData    = $urandom;
                dReqMask    = 4'($urandom_range(0, 15));
                memReqReady = ($urandom_range(0, 99) < 60);
                memRspValid = ($urandom_range(0, 99) < rsp_pct);
                memRspData  = $urandom;
                step();
            end
        end
        reset = 0;
        quiet();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
